coin_acceptor: RTL and testbench

Front-end stage that sits directly upstream of the vending FSM and drives its 2-bit coin input. It synchronizes and debounces two raw coin-sensor lines (nickel, dime) and turns each clean rising edge into a coin event. Events are buffered in a small FIFO. Each event is presented as a single-cycle coin code: 2'b01 = 5c, 2'b10 = 10c, 2'b00 = no coin. A downstream accept_en lets the FSM stall delivery (tied to ~dispense at top level) so no coin is lost during the dispense cycle.

---
 rtl/coin_acceptor.sv | 177 +++++++++++++++++
 tb/tb_coin_acceptor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-sensor front end: sync + debounce two sensor lines, queue coin events, deliver one code per cycle.
// Optional COIN_TOTAL_EN adds a saturating total_credit output.

module coin_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic event_pulse
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_d;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] low_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
            low_cnt <= '0;
        end else begin
            sync_1  <= raw;
            sync_2  <= sync_1;
            level_d <= level;

            if (sync_2 != level) begin
                if (cnt == LAST) begin
                    level <= sync_2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end

            // A line must be seen idle low before its rising edges count as coins.
            if (!armed) begin
                if (sync_2) begin
                    low_cnt <= '0;
                end else if (low_cnt == LAST) begin
                    armed   <= 1'b1;
                    low_cnt <= '0;
                end else begin
                    low_cnt <= low_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign event_pulse = armed & level & ~level_d;
endmodule

module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       fifo_full,
    output logic       coin_rejected
`ifdef COIN_TOTAL_EN
    ,
    output logic [15:0] total_credit
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic             nickel_evt;
    logic             dime_evt;
    logic             jam;
    logic             single;
    logic [1:0]       evt_code;
    logic             pop;
    logic             push;
    logic             overflow;
    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occupancy;

    coin_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_nickel (
        .clk         (clk),
        .reset       (reset),
        .raw         (nickel_raw),
        .event_pulse (nickel_evt)
    );

    coin_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dime (
        .clk         (clk),
        .reset       (reset),
        .raw         (dime_raw),
        .event_pulse (dime_evt)
    );

    assign jam       = nickel_evt & dime_evt;
    assign single    = nickel_evt ^ dime_evt;
    assign evt_code  = nickel_evt ? 2'b01 : 2'b10;
    assign fifo_full = (occupancy == OCC_W'(FIFO_DEPTH));
    assign pop       = (occupancy != '0) & accept_en;
    // A pop frees the slot on the same edge, so a full FIFO still takes the event.
    assign push      = single & (~fifo_full | pop);
    assign overflow  = single & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= evt_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coin          <= 2'b00;
            coin_rejected <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            occupancy     <= '0;
        end else begin
            coin          <= pop ? mem[rd_ptr] : 2'b00;
            coin_rejected <= jam | overflow;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef COIN_TOTAL_EN
    logic [15:0] coin_value;
    logic [16:0] credit_sum;

    always_comb begin
        coin_value = 16'd0;
        case (coin)
            2'b01:   coin_value = 16'd5;
            2'b10:   coin_value = 16'd10;
            default: coin_value = 16'd0;
        endcase
    end

    assign credit_sum = {1'b0, total_credit} + {1'b0, coin_value};

    always_ff @(posedge clk) begin
        if (reset) begin
            total_credit <= 16'd0;
        end else if (credit_sum[16]) begin
            total_credit <= 16'hFFFF;
        end else begin
            total_credit <= credit_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: per-cycle vector table plus FIFO, reset and credit sequences.

module tb_coin_acceptor;
    logic       clk;
    logic       reset;
    logic       nickel_raw;
    logic       dime_raw;
    logic       accept_en;
    logic [1:0] coin;
    logic       fifo_full;
    logic       coin_rejected;
`ifdef COIN_TOTAL_EN
    logic [15:0] total_credit;
`endif

    int compared = 0;
    int mismatched = 0;
    int n_nickel = 0;
    int n_dime = 0;
    int n_rej = 0;

    typedef struct {
        logic       nickel;
        logic       dime;
        logic       accept;
        logic [1:0] exp_coin;
        logic       exp_full;
        logic       exp_rej;
    } vec_t;

    vec_t vecs [40];
    logic [1:0] seq [16];

    coin_acceptor dut (
        .clk           (clk),
        .reset         (reset),
        .nickel_raw    (nickel_raw),
        .dime_raw      (dime_raw),
        .accept_en     (accept_en),
        .coin          (coin),
        .fifo_full     (fifo_full),
        .coin_rejected (coin_rejected)
`ifdef COIN_TOTAL_EN
        ,
        .total_credit  (total_credit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (coin == 2'b01) n_nickel++;
            if (coin == 2'b10) n_dime++;
            if (coin_rejected) n_rej++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic dime_pulse(input int hi, input int lo);
        dime_raw = 1'b1;
        repeat (hi) step();
        dime_raw = 1'b0;
        repeat (lo) step();
    endtask

    task automatic nickel_pulse(input int hi, input int lo);
        nickel_raw = 1'b1;
        repeat (hi) step();
        nickel_raw = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        int base_rej;
        int base_dime;

        for (int i = 0; i < 40; i++) begin
            vecs[i].nickel   = (i < 10) || (i >= 24 && i < 30);
            vecs[i].dime     = (i >= 16 && i < 19) || (i >= 24 && i < 30);
            vecs[i].accept   = 1'b1;
            vecs[i].exp_coin = 2'b00;
            vecs[i].exp_full = 1'b0;
            vecs[i].exp_rej  = 1'b0;
        end
        vecs[7].exp_coin = 2'b01;
        vecs[30].exp_rej = 1'b1;

        reset = 1'b1;
        nickel_raw = 1'b1;
        dime_raw = 1'b0;
        accept_en = 1'b1;
        repeat (3) step();
        check("reset_coin", int'(coin), 0);
        check("reset_full", int'(fifo_full), 0);
        check("reset_rej", int'(coin_rejected), 0);

        reset = 1'b0;
        repeat (8) step();
        nickel_raw = 1'b0;
        repeat (12) step();
        check("held_through_reset_no_coin", n_nickel, 0);

        for (int i = 0; i < 40; i++) begin
            nickel_raw = vecs[i].nickel;
            dime_raw   = vecs[i].dime;
            accept_en  = vecs[i].accept;
            step();
            check($sformatf("vec%0d_coin", i), int'(coin), int'(vecs[i].exp_coin));
            check($sformatf("vec%0d_full", i), int'(fifo_full), int'(vecs[i].exp_full));
            check($sformatf("vec%0d_rej", i), int'(coin_rejected), int'(vecs[i].exp_rej));
        end
        check("table_nickel_total", n_nickel, 1);
        check("table_dime_total", n_dime, 0);
        check("table_rej_total", n_rej, 1);

        accept_en = 1'b0;
        base_rej = n_rej;
        repeat (3) dime_pulse(6, 6);
        check("fill3_full", int'(fifo_full), 0);
        dime_pulse(6, 6);
        check("fill4_full", int'(fifo_full), 1);
        check("fill4_no_rej", n_rej - base_rej, 0);
        dime_pulse(6, 6);
        check("overflow_rej", n_rej - base_rej, 1);
        check("overflow_full", int'(fifo_full), 1);
        accept_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            seq[k] = coin;
        end
        for (int k = 0; k < 6; k++)
            check($sformatf("drain_coin%0d", k), int'(seq[k]), (k < 4) ? 2 : 0);
        check("drain_full", int'(fifo_full), 0);

        accept_en = 1'b0;
        base_rej = n_rej;
        repeat (4) dime_pulse(6, 6);
        check("refill_full", int'(fifo_full), 1);
        nickel_raw = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 6) begin
                nickel_raw = 1'b0;
                accept_en = 1'b1;
            end
            step();
            seq[k] = coin;
        end
        for (int k = 0; k < 14; k++)
            check($sformatf("pushpop_coin%0d", k), int'(seq[k]),
                  (k >= 6 && k <= 9) ? 2 : ((k == 10) ? 1 : 0));
        check("pushpop_no_rej", n_rej - base_rej, 0);
        check("pushpop_full_after", int'(fifo_full), 0);

        accept_en = 1'b0;
        repeat (2) dime_pulse(6, 6);
        reset = 1'b1;
        step();
        check("midreset_coin", int'(coin), 0);
        check("midreset_full", int'(fifo_full), 0);
        reset = 1'b0;
        accept_en = 1'b1;
        base_dime = n_dime;
        repeat (8) step();
        check("midreset_discarded", n_dime - base_dime, 0);

`ifdef COIN_TOTAL_EN
        reset = 1'b1;
        step();
        step();
        check("credit_reset", int'(total_credit), 0);
        reset = 1'b0;
        repeat (8) step();
        nickel_pulse(6, 6);
        dime_pulse(6, 6);
        dime_pulse(6, 6);
        check("credit_25", int'(total_credit), 25);
        repeat (6552) dime_pulse(5, 5);
        repeat (4) step();
        check("credit_saturated", int'(total_credit), 65535);
        nickel_pulse(6, 6);
        check("credit_stays_saturated", int'(total_credit), 65535);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
